// File: rtl/countdown_timer_4hz.sv
// Seconds countdown timer (00..99) advanced by rising edges of a 4 Hz square wave
// that is sampled as data in the clock_in domain; drives BCD digits and game status flags.
module countdown_timer_4hz #(
    parameter int         TICKS_PER_SEC = 4,
    parameter logic [3:0] INIT_TENS     = 4'd6,
    parameter logic [3:0] INIT_ONES     = 4'd0,
    parameter int         WARN_SECONDS  = 10
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       tick_clk,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse,
    output logic       blink
);

    localparam int            QW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [QW-1:0] QLAST    = QW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]    WARN_CNT = 7'(WARN_SECONDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [3:0]    tens_r, tens_nxt_s;
    logic [3:0]    ones_r, ones_nxt_s;
    logic [QW-1:0] qcnt_r, qcnt_nxt_s;
    logic          tick_q_r;
    logic          blink_r, blink_nxt_s;
    logic          pulse_r, pulse_nxt_s;
    logic          tick_rise_s;
    logic [6:0]    count_s;
    logic          running_s, expired_s;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign tick_rise_s = tick_clk & ~tick_q_r;
    assign count_s     = ({3'd0, tens_r} * 7'd10) + {3'd0, ones_r};

    // State and datapath registers; tick_q resets high so a high tick at reset is not an edge
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            tens_r   <= INIT_TENS;
            ones_r   <= INIT_ONES;
            qcnt_r   <= '0;
            tick_q_r <= 1'b1;
            blink_r  <= 1'b0;
            pulse_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            tens_r   <= tens_nxt_s;
            ones_r   <= ones_nxt_s;
            qcnt_r   <= qcnt_nxt_s;
            tick_q_r <= tick_clk;
            blink_r  <= blink_nxt_s;
            pulse_r  <= pulse_nxt_s;
        end
    end

    // Next-state and datapath logic; priority load > pause > start > tick
    always_comb begin
        state_nxt_s = state_r;
        tens_nxt_s  = tens_r;
        ones_nxt_s  = ones_r;
        qcnt_nxt_s  = qcnt_r;
        blink_nxt_s = blink_r;
        pulse_nxt_s = 1'b0;
        if (load) begin
            state_nxt_s = ST_IDLE;
            tens_nxt_s  = clamp_bcd(load_tens);
            ones_nxt_s  = clamp_bcd(load_ones);
            qcnt_nxt_s  = '0;
            blink_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_PAUSED: begin
                    blink_nxt_s = 1'b0;
                    if (start && !pause && (count_s != 7'd0)) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nxt_s = ST_PAUSED;
                        blink_nxt_s = 1'b0;
                    end else if (tick_rise_s) begin
                        blink_nxt_s = (count_s <= WARN_CNT) ? ~blink_r : 1'b0;
                        if (qcnt_r == QLAST) begin
                            qcnt_nxt_s = '0;
                            if (ones_r == 4'd0) begin
                                ones_nxt_s = 4'd9;
                                tens_nxt_s = tens_r - 4'd1;
                            end else begin
                                ones_nxt_s = ones_r - 4'd1;
                                tens_nxt_s = tens_r;
                            end
                            // Final second consumed: expiry lands on the same edge as 01 -> 00
                            if (count_s == 7'd1) begin
                                state_nxt_s = ST_EXPIRED;
                                pulse_nxt_s = 1'b1;
                                blink_nxt_s = 1'b1;
                            end else begin
                                state_nxt_s = ST_RUN;
                            end
                        end else begin
                            qcnt_nxt_s = qcnt_r + QW'(1);
                        end
                    end else begin
                        blink_nxt_s = (count_s > WARN_CNT) ? 1'b0 : blink_r;
                    end
                end
                ST_EXPIRED: begin
                    blink_nxt_s = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    blink_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Status decode from the registered state
    always_comb begin
        running_s = 1'b0;
        expired_s = 1'b0;
        case (state_r)
            ST_RUN:     running_s = 1'b1;
            ST_EXPIRED: expired_s = 1'b1;
            default: begin
                running_s = 1'b0;
                expired_s = 1'b0;
            end
        endcase
    end

    assign tens         = tens_r;
    assign ones         = ones_r;
    assign running      = running_s;
    assign expired      = expired_s;
    assign expire_pulse = pulse_r;
    assign blink        = blink_r;

endmodule

// File: tb/tb_countdown_timer_4hz.sv
// Bench for countdown_timer_4hz: a behavioural seconds model feeds a scoreboard every cycle,
// plus directed checks of the reset, count, pause, BCD, priority and blink scenarios.
module tb_countdown_timer_4hz;

    logic       clock_in;
    logic       reset;
    logic       tick_clk;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       start;
    logic       pause;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       expire_pulse;
    logic       blink;

    int nvec = 0;
    int nerr = 0;
    int ph   = 0;
    bit tick_adv = 1'b0;

    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_PAUSED = 2'd2, M_EXP = 2'd3;

    typedef struct packed {
        logic [1:0] st;
        logic [6:0] cnt;
        logic [1:0] q;
        logic       tq;
        logic       blk;
        logic       pls;
    } mdl_t;

    mdl_t m;
    mdl_t exp_q[$];

    countdown_timer_4hz dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .tick_clk     (tick_clk),
        .load         (load),
        .load_tens    (load_tens),
        .load_ones    (load_ones),
        .start        (start),
        .pause        (pause),
        .tens         (tens),
        .ones         (ones),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse),
        .blink        (blink)
    );

    always #25 clock_in = ~clock_in;

    function automatic logic [6:0] clampv(input logic [3:0] d);
        return (d > 4'd9) ? 7'd9 : {3'd0, d};
    endfunction

    // Behavioural model: whole-second count held as a binary number
    function automatic mdl_t mdl_next(input mdl_t c, input logic rst, input logic ld,
                                      input logic [3:0] lt, input logic [3:0] lo,
                                      input logic st, input logic ps, input logic tk);
        mdl_t n;
        logic rise;
        n     = c;
        n.pls = 1'b0;
        n.tq  = tk;
        rise  = tk & ~c.tq;
        if (rst) begin
            n.st = M_IDLE; n.cnt = 7'd60; n.q = 2'd0; n.tq = 1'b1; n.blk = 1'b0;
        end else if (ld) begin
            n.st = M_IDLE; n.cnt = clampv(lt) * 7'd10 + clampv(lo); n.q = 2'd0; n.blk = 1'b0;
        end else if (c.st == M_RUN) begin
            if (ps) begin
                n.st = M_PAUSED; n.blk = 1'b0;
            end else if (rise) begin
                n.blk = (c.cnt <= 7'd10) ? ~c.blk : 1'b0;
                if (c.q == 2'd3) begin
                    n.q   = 2'd0;
                    n.cnt = c.cnt - 7'd1;
                    if (n.cnt == 7'd0) begin
                        n.st = M_EXP; n.pls = 1'b1; n.blk = 1'b1;
                    end
                end else begin
                    n.q = c.q + 2'd1;
                end
            end else if (c.cnt > 7'd10) begin
                n.blk = 1'b0;
            end
        end else if (c.st == M_EXP) begin
            n.blk = 1'b1;
        end else begin
            n.blk = 1'b0;
            if (st && !ps && (c.cnt != 7'd0)) n.st = M_RUN;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        nvec++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Scoreboard producer: expected post-edge state from the inputs sampled at this edge
    always @(posedge clock_in) begin
        exp_q.push_back(mdl_next(m, reset, load, load_tens, load_ones, start, pause, tick_clk));
        m <= mdl_next(m, reset, load, load_tens, load_ones, start, pause, tick_clk);
    end

    // Scoreboard consumer: compare registered outputs half a cycle after the edge
    always @(negedge clock_in) begin
        if (exp_q.size() > 0) begin
            chk("sb_tens",    {4'd0, tens},    {4'd0, 4'(exp_q[0].cnt / 7'd10)});
            chk("sb_ones",    {4'd0, ones},    {4'd0, 4'(exp_q[0].cnt % 7'd10)});
            chk("sb_running", {7'd0, running}, {7'd0, exp_q[0].st == M_RUN});
            chk("sb_expired", {7'd0, expired}, {7'd0, exp_q[0].st == M_EXP});
            chk("sb_pulse",   {7'd0, expire_pulse}, {7'd0, exp_q[0].pls});
            chk("sb_blink",   {7'd0, blink},   {7'd0, exp_q[0].blk});
            exp_q.delete(0);
        end
    end

    task automatic cyc();
        @(negedge clock_in);
        if (tick_adv) begin
            ph       = (ph + 1) % 8;
            tick_clk = (ph < 4);
        end
    endtask

    task automatic rises(input int n);
        int got;
        got      = 0;
        tick_adv = 1'b1;
        while (got < n) begin
            cyc();
            if (ph == 0) got++;
        end
        cyc();
        tick_adv = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; load_tens = t; load_ones = o;
        cyc();
        load = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_digits(input string tag, input logic [3:0] t, input logic [3:0] o);
        chk(tag, {tens, ones}, {t, o});
    endtask

    initial begin
        clock_in = 1'b0; reset = 1'b1; tick_clk = 1'b1; load = 1'b0;
        load_tens = 4'd0; load_ones = 4'd0; start = 1'b0; pause = 1'b0;

        // T1 reset with tick high
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk_digits("t1_digits", 4'd6, 4'd0);
        chk("t1_running", {7'd0, running}, 8'd0);

        // T2 count 03 to expiry
        do_load(4'd0, 4'd3);
        go();
        rises(4);  chk_digits("t2_02", 4'd0, 4'd2);
        rises(4);  chk_digits("t2_01", 4'd0, 4'd1);
        rises(4);  chk_digits("t2_00", 4'd0, 4'd0);
        chk("t2_expired", {7'd0, expired}, 8'd1);
        chk("t2_pulse",   {7'd0, expire_pulse}, 8'd1);
        chk("t2_running", {7'd0, running}, 8'd0);
        cyc();
        chk("t2_pulse_end", {7'd0, expire_pulse}, 8'd0);

        // T3 pause keeps sub-second phase
        do_load(4'd1, 4'd0);
        go();
        rises(6);  chk_digits("t3_09", 4'd0, 4'd9);
        pause = 1'b1;
        cyc();
        chk("t3_paused", {7'd0, running}, 8'd0);
        rises(20); chk_digits("t3_hold", 4'd0, 4'd9);
        pause = 1'b0;
        go();
        rises(2);  chk_digits("t3_08", 4'd0, 4'd8);

        // T4 BCD borrow and clamp
        do_load(4'd2, 4'd0);
        go();
        rises(4);  chk_digits("t4_19", 4'd1, 4'd9);
        do_load(4'hC, 4'hF);
        chk_digits("t4_clamp", 4'd9, 4'd9);

        // T5 priorities
        start = 1'b1; pause = 1'b1;
        cyc();
        start = 1'b0; pause = 1'b0;
        chk("t5_sp_idle", {7'd0, running}, 8'd0);
        go();
        chk("t5_run", {7'd0, running}, 8'd1);
        tick_adv = 1'b1;
        do cyc(); while (ph != 0);
        load = 1'b1; load_tens = 4'd3; load_ones = 4'd7;
        cyc();
        load = 1'b0; tick_adv = 1'b0;
        chk_digits("t5_load_tick", 4'd3, 4'd7);
        chk("t5_load_idle", {7'd0, running}, 8'd0);

        // T6 blink window, expired behaviour, mid-run reset
        do_load(4'd1, 4'd1);
        go();
        rises(4);  chk_digits("t6_10", 4'd1, 4'd0);
        chk("t6_blink_off", {7'd0, blink}, 8'd0);
        rises(1);  chk("t6_blink_on",  {7'd0, blink}, 8'd1);
        rises(1);  chk("t6_blink_tog", {7'd0, blink}, 8'd0);
        rises(38);
        chk("t6_expired", {7'd0, expired}, 8'd1);
        chk("t6_exp_blink", {7'd0, blink}, 8'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6_start_ign", {7'd0, expired}, 8'd1);
        chk_digits("t6_00", 4'd0, 4'd0);
        do_load(4'd5, 4'd0);
        go();
        rises(3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_digits("t6_reset", 4'd6, 4'd0);
        chk("t6_reset_run", {7'd0, running}, 8'd0);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
